// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types for the RISC-V top-level blocks
package riscv_pkg;

   // Owner of the DMEM port. DBG_OWN is only held across locked debug bursts.
   typedef enum logic {
      CPU_OWN = 1'b0,
      DBG_OWN = 1'b1
   } arb_state_t;

   // Width of the debug starvation counter; MAX_WAIT must fit in it.
   localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU / debug arbiter for the single-port data memory
//
// Shares one DMEM port between the CPU load/store path and the debug/loader
// port. The CPU wins by default. A pending debug request is granted when the
// CPU is idle, or after MAX_WAIT consecutive denials, in which case the CPU is
// stalled for that cycle. A debug grant with dbg_lock holds the memory for the
// debug side until a request or idle cycle arrives with dbg_lock low.
//
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata           CPU access request
//   cpu_rdata                       CPU load data (mem_rdata passthrough)
//   cpu_stall                       CPU must hold PC and suppress writes
//   dbg_req/we/lock/addr/wdata      debug access request, held until dbg_gnt
//   dbg_gnt                         debug access performed this cycle
//   dbg_rvalid, dbg_rdata           registered debug read data
//   mem_we/addr/wdata, mem_rdata    DMEM port
module dmem_arbiter
   import riscv_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WAIT   = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_stall,
   input  logic                  dbg_req,
   input  logic                  dbg_we,
   input  logic                  dbg_lock,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   input  logic [DATA_WIDTH-1:0] dbg_wdata,
   output logic                  dbg_gnt,
   output logic                  dbg_rvalid,
   output logic [DATA_WIDTH-1:0] dbg_rdata,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam logic [WAIT_CNT_W-1:0] MAX_CNT = WAIT_CNT_W'(MAX_WAIT);

   arb_state_t             state;
   logic [WAIT_CNT_W-1:0]  wait_cnt;
   logic                   starved;

   // The counter never passes MAX_CNT, so equality is the saturation test.
   assign starved   = (wait_cnt == MAX_CNT);
   assign cpu_rdata = mem_rdata;

   // Grant, stall and memory mux are combinational so an unstalled CPU keeps
   // its single-cycle memory timing. Everything is gated by reset_n so that a
   // reset in the middle of a burst cannot leave a partial write behind.
   always_comb begin
      dbg_gnt   = 1'b0;
      cpu_stall = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      if (reset_n) begin
         if (state == DBG_OWN) begin
            dbg_gnt = dbg_req;
         end else begin
            dbg_gnt = dbg_req & (~cpu_req | starved);
         end
         // In CPU_OWN a debug grant with cpu_req high can only be a forced one.
         cpu_stall = cpu_req & ((state == DBG_OWN) | dbg_gnt);
         if (dbg_gnt) begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_we    = dbg_we;
         end else if (!cpu_stall) begin
            mem_we = cpu_req & cpu_we;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= CPU_OWN;
         wait_cnt   <= '0;
         dbg_rvalid <= 1'b0;
         dbg_rdata  <= '0;
      end else begin
         dbg_rvalid <= dbg_gnt & ~dbg_we;
         if (dbg_gnt & ~dbg_we) begin
            dbg_rdata <= mem_rdata;
         end

         if (state == CPU_OWN) begin
            // Count only cycles where debug is actually being denied.
            if (dbg_req & cpu_req & ~dbg_gnt) begin
               wait_cnt <= wait_cnt + 1'b1;
            end else begin
               wait_cnt <= '0;
            end
            if (dbg_gnt & dbg_lock) begin
               state <= DBG_OWN;
            end
         end else begin
            wait_cnt <= '0;
            // Every request is granted here, so a low dbg_lock always ends
            // the burst, whether or not a request is present.
            if (!dbg_lock) begin
               state <= CPU_OWN;
            end
         end
      end
   end

endmodule
